// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 19-bit accumulator CPU.
// It waits on memory ready handshakes and bounds call depth against a hardware return stack.
module multicycle_controller #(
    parameter int IW          = 19,
    parameter int AW          = 12,
    parameter int STACK_DEPTH = 8,
    parameter int SDW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic           clock,
    input  logic           init_signal,
    input  logic [IW-1:0]  instr,
    output logic           instr_req,
    input  logic           instr_ready,
    output logic           data_req,
    input  logic           data_ready,
    input  logic           Zero,
    input  logic           CarryOut,
    output logic           ir_load,
    output logic           pc_write,
    output logic [1:0]     select_address,
    output logic [2:0]     ALUfunction,
    output logic [1:0]     sh_roFunction,
    output logic           selectAluArg,
    output logic           selectR2,
    output logic [1:0]     selectToWrite,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           enableZero,
    output logic           enableCarry,
    output logic           push,
    output logic           pop,
    output logic [SDW-1:0] stack_depth,
    output logic           fault,
    output logic [1:0]     fault_code
);

    if (AW > IW - 6) begin : gParamCheck
        $error("address field overlaps the opcode field");
    end

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StFault
    } state_e;

    typedef struct packed {
        logic       pcWrite;
        logic [1:0] selAddr;
        logic [2:0] aluFn;
        logic [1:0] shFn;
        logic       selAluArg;
        logic       selR2;
        logic [1:0] selWrite;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       enZero;
        logic       enCarry;
        logic       doPush;
        logic       doPop;
        logic       dataReq;
    } ctl_t;

    state_e         state_q, state_d;
    logic [5:0]     op_q, op_d;
    ctl_t           ctl_q, ctl_d;
    logic [SDW-1:0] depth_q, depth_d;
    logic [1:0]     code_q, code_d;
    logic           fault_q;

    logic unusedInstrBits;
    assign unusedInstrBits = ^instr[IW-7:0];

    logic opIsAlu, opIsShift, opIsLoad, opIsStore, opIsBranch;
    logic opIsJmp, opIsCall, opIsRet, opIllegal;
    logic flagSel, branchTaken, canPush, canPop;

    assign opIsAlu    = ~op_q[5];
    assign opIsShift  = (op_q[5:3] == 3'b110);
    assign opIsLoad   = (op_q[5:1] == 5'b10000);
    assign opIsStore  = (op_q[5:1] == 5'b10001);
    assign opIsBranch = (op_q[5:3] == 3'b101);
    assign opIsJmp    = (op_q[5:1] == 5'b11100);
    assign opIsCall   = (op_q[5:1] == 5'b11101);
    assign opIsRet    = (op_q == 6'b111100);
    assign opIllegal  = ~(opIsAlu | opIsShift | opIsLoad | opIsStore | opIsBranch |
                          opIsJmp | opIsCall | opIsRet);

    // Flags are already stable during DECODE, so the branch decision is registered one edge early.
    assign flagSel     = op_q[2] ? CarryOut : Zero;
    assign branchTaken = op_q[1] ? flagSel : ~flagSel;
    assign canPush     = (depth_q < SDW'(STACK_DEPTH));
    assign canPop      = (depth_q != '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl_d   = '0;
        depth_d = depth_q;
        code_d  = code_q;
        case (state_q)
            StFetch: begin
                if (instr_ready) begin
                    op_d    = instr[IW-1:IW-6];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opIllegal) begin
                    state_d = StFault;
                    code_d  = 2'b01;
                end else if (opIsLoad || opIsStore) begin
                    state_d        = StMem;
                    ctl_d.dataReq  = 1'b1;
                    ctl_d.memRead  = opIsLoad;
                    ctl_d.memWrite = opIsStore;
                end else begin
                    state_d = StExec;
                    if (opIsAlu) begin
                        ctl_d.aluFn     = op_q[3:1];
                        ctl_d.selAluArg = ~op_q[4];
                        ctl_d.selR2     = 1'b1;
                    end
                    if (opIsShift) begin
                        ctl_d.shFn = op_q[2:1];
                    end
                    if (opIsBranch && branchTaken) begin
                        ctl_d.pcWrite = 1'b1;
                        ctl_d.selAddr = 2'b01;
                    end
                    if (opIsJmp || (opIsCall && canPush)) begin
                        ctl_d.pcWrite = 1'b1;
                        ctl_d.selAddr = 2'b10;
                        ctl_d.doPush  = opIsCall;
                    end
                    if (opIsRet && canPop) begin
                        ctl_d.pcWrite = 1'b1;
                        ctl_d.selAddr = 2'b11;
                        ctl_d.doPop   = 1'b1;
                    end
                end
            end
            StExec: begin
                state_d = StFetch;
                if (ctl_q.doPush) begin
                    depth_d = depth_q + SDW'(1);
                end else if (ctl_q.doPop) begin
                    depth_d = depth_q - SDW'(1);
                end
                if (opIsAlu || opIsShift) begin
                    state_d        = StWb;
                    ctl_d          = ctl_q;
                    ctl_d.regWrite = 1'b1;
                    ctl_d.selWrite = opIsShift ? 2'b01 : 2'b00;
                    ctl_d.enZero   = opIsAlu;
                    ctl_d.enCarry  = opIsAlu;
                end else if (opIsCall && !canPush) begin
                    state_d = StFault;
                    code_d  = 2'b10;
                end else if (opIsRet && !canPop) begin
                    state_d = StFault;
                    code_d  = 2'b11;
                end
            end
            StMem: begin
                if (!data_ready) begin
                    ctl_d = ctl_q;
                end else if (opIsLoad) begin
                    state_d        = StWb;
                    ctl_d.regWrite = 1'b1;
                    ctl_d.selWrite = 2'b10;
                end else begin
                    state_d = StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StFault: state_d = StFault;
            default: state_d = StFetch;
        endcase
    end

    // Control outputs are registered on the edge that enters the state they belong to.
    always_ff @(posedge clock or posedge init_signal) begin
        if (init_signal) begin
            state_q <= StFetch;
            op_q    <= '0;
            ctl_q   <= '0;
            depth_q <= '0;
            code_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
            depth_q <= depth_d;
            code_q  <= code_d;
            fault_q <= (state_d == StFault);
        end
    end

    assign instr_req      = (state_q == StFetch);
    assign ir_load        = (state_q == StFetch) && instr_ready;
    assign pc_write       = ctl_q.pcWrite | ir_load;
    assign select_address = ctl_q.selAddr;
    assign ALUfunction    = ctl_q.aluFn;
    assign sh_roFunction  = ctl_q.shFn;
    assign selectAluArg   = ctl_q.selAluArg;
    assign selectR2       = ctl_q.selR2;
    assign selectToWrite  = ctl_q.selWrite;
    assign reg_write      = ctl_q.regWrite;
    assign mem_read       = ctl_q.memRead;
    assign mem_write      = ctl_q.memWrite;
    assign enableZero     = ctl_q.enZero;
    assign enableCarry    = ctl_q.enCarry;
    assign push           = ctl_q.doPush;
    assign pop            = ctl_q.doPop;
    assign data_req       = ctl_q.dataReq;
    assign stack_depth    = depth_q;
    assign fault          = fault_q;
    assign fault_code     = code_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model emits the expected
// per-cycle output vector and a single compare process checks the DUT against it.
module tb_multicycle_controller;

    localparam int IW  = 19;
    localparam int SD  = 8;
    localparam int SDW = 4;

    logic           clock = 1'b0;
    logic           init_signal = 1'b1;
    logic [IW-1:0]  instr = '0;
    logic           instr_req, instr_ready = 1'b0;
    logic           data_req, data_ready = 1'b0;
    logic           Zero = 1'b0, CarryOut = 1'b0;
    logic           ir_load, pc_write;
    logic [1:0]     select_address;
    logic [2:0]     ALUfunction;
    logic [1:0]     sh_roFunction;
    logic           selectAluArg, selectR2;
    logic [1:0]     selectToWrite;
    logic           reg_write, mem_read, mem_write, enableZero, enableCarry, push, pop;
    logic [SDW-1:0] stack_depth;
    logic           fault;
    logic [1:0]     fault_code;

    multicycle_controller #(.IW(IW), .AW(12), .STACK_DEPTH(SD), .SDW(SDW)) dut (
        .clock(clock), .init_signal(init_signal), .instr(instr),
        .instr_req(instr_req), .instr_ready(instr_ready),
        .data_req(data_req), .data_ready(data_ready),
        .Zero(Zero), .CarryOut(CarryOut),
        .ir_load(ir_load), .pc_write(pc_write), .select_address(select_address),
        .ALUfunction(ALUfunction), .sh_roFunction(sh_roFunction),
        .selectAluArg(selectAluArg), .selectR2(selectR2), .selectToWrite(selectToWrite),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .enableZero(enableZero), .enableCarry(enableCarry), .push(push), .pop(pop),
        .stack_depth(stack_depth), .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       instrReq;
        logic       dataReq;
        logic       irLoad;
        logic       pcWrite;
        logic [1:0] selAddr;
        logic [2:0] aluFn;
        logic [1:0] shFn;
        logic       selAluArg;
        logic       selR2;
        logic [1:0] selWrite;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       enZero;
        logic       enCarry;
        logic       doPush;
        logic       doPop;
        logic [3:0] depth;
        logic       isFault;
        logic [1:0] faultCode;
    } outVec_t;

    outVec_t    expQ[$];
    outVec_t    cmpExp, cmpAct;
    int         testsRun = 0;
    int         testsFailed = 0;
    int         cycleNo = 0;
    string      curName = "reset";

    int         mDepth = 0;
    logic       mFault = 1'b0;
    logic [1:0] mCode = 2'b00;

    always @(negedge clock) begin
        cycleNo++;
        if (expQ.size() > 0) begin
            cmpExp = expQ.pop_front();
            cmpAct = {instr_req, data_req, ir_load, pc_write, select_address, ALUfunction,
                      sh_roFunction, selectAluArg, selectR2, selectToWrite, reg_write,
                      mem_read, mem_write, enableZero, enableCarry, push, pop,
                      stack_depth, fault, fault_code};
            testsRun++;
            if (cmpAct !== cmpExp) begin
                testsFailed++;
                $display("[TB] FAIL %s cycle %0d: outputs %h, expected %h",
                         curName, cycleNo, cmpAct, cmpExp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outVec_t idleVec();
        outVec_t v;
        v           = '0;
        v.depth     = 4'(mDepth);
        v.isFault   = mFault;
        v.faultCode = mCode;
        return v;
    endfunction

    function automatic logic isIllegal(input logic [5:0] op);
        return (op[5:2] == 4'b1001) || (op == 6'b111101) || (op[5:1] == 5'b11111);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle(input outVec_t e);
        expQ.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic randomReadies();
        instr_ready = 1'($urandom);
        data_ready  = 1'($urandom);
    endtask

    task automatic resetDut();
        init_signal = 1'b1;
        instr_ready = 1'b0;
        data_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        init_signal = 1'b0;
        mDepth = 0;
        mFault = 1'b0;
        mCode  = 2'b00;
    endtask

    task automatic enterFault(input logic [1:0] code);
        mFault = 1'b1;
        mCode  = code;
        repeat (3) begin
            randomReadies();
            stepCycle(idleVec());
        end
    endtask

    // Drives one instruction and queues the expected outputs for each cycle it takes.
    task automatic applyStimulus(input logic [5:0] op, input int fetchWait, input int memWait,
                                 input logic z, input logic c, output int cycles);
        outVec_t e;
        logic    taken;
        cycles   = 0;
        curName  = $sformatf("op_%b", op);
        Zero     = z;
        CarryOut = c;
        instr    = {op, 13'($urandom)};
        for (int w = 0; w <= fetchWait; w++) begin
            e          = idleVec();
            e.instrReq = 1'b1;
            instr_ready = (w == fetchWait);
            data_ready  = 1'($urandom);
            if (w == fetchWait) begin
                e.irLoad  = 1'b1;
                e.pcWrite = 1'b1;
            end
            stepCycle(e);
            cycles++;
        end
        instr = 19'($urandom);
        randomReadies();
        stepCycle(idleVec());
        cycles++;
        if (isIllegal(op)) begin
            enterFault(2'b01);
            return;
        end
        if (op[5:2] == 4'b1000) begin
            for (int w = 0; w <= memWait; w++) begin
                e          = idleVec();
                e.dataReq  = 1'b1;
                e.memRead  = ~op[1];
                e.memWrite = op[1];
                instr_ready = 1'($urandom);
                data_ready  = (w == memWait);
                stepCycle(e);
                cycles++;
            end
            if (!op[1]) begin
                e          = idleVec();
                e.regWrite = 1'b1;
                e.selWrite = 2'b10;
                randomReadies();
                stepCycle(e);
                cycles++;
            end
            return;
        end
        e = idleVec();
        randomReadies();
        if (!op[5]) begin
            e.aluFn     = op[3:1];
            e.selAluArg = ~op[4];
            e.selR2     = 1'b1;
            stepCycle(e);
            e.regWrite = 1'b1;
            e.selWrite = 2'b00;
            e.enZero   = 1'b1;
            e.enCarry  = 1'b1;
            randomReadies();
            stepCycle(e);
            cycles += 2;
        end else if (op[5:3] == 3'b110) begin
            e.shFn = op[2:1];
            stepCycle(e);
            e.regWrite = 1'b1;
            e.selWrite = 2'b01;
            randomReadies();
            stepCycle(e);
            cycles += 2;
        end else if (op[5:3] == 3'b101) begin
            case (op[2:1])
                2'b00:   taken = !z;
                2'b01:   taken = z;
                2'b10:   taken = !c;
                default: taken = c;
            endcase
            e.pcWrite = taken;
            e.selAddr = taken ? 2'b01 : 2'b00;
            stepCycle(e);
            cycles++;
        end else if (op[5:1] == 5'b11100) begin
            e.pcWrite = 1'b1;
            e.selAddr = 2'b10;
            stepCycle(e);
            cycles++;
        end else if (op[5:1] == 5'b11101) begin
            if (mDepth < SD) begin
                e.pcWrite = 1'b1;
                e.selAddr = 2'b10;
                e.doPush  = 1'b1;
                stepCycle(e);
                mDepth++;
            end else begin
                stepCycle(e);
                enterFault(2'b10);
            end
            cycles++;
        end else begin
            if (mDepth > 0) begin
                e.pcWrite = 1'b1;
                e.selAddr = 2'b11;
                e.doPop   = 1'b1;
                stepCycle(e);
                mDepth--;
            end else begin
                stepCycle(e);
                enterFault(2'b11);
            end
            cycles++;
        end
    endtask

    initial begin
        int         cyc;
        logic [5:0] op;

        $display("[TB] starting multicycle_controller bench");
        resetDut();
        checkOutput("rstInstrReq", 32'(instr_req), 32'd1);
        checkOutput("rstDataReq", 32'(data_req), 32'd0);
        checkOutput("rstRegWrite", 32'(reg_write), 32'd0);
        checkOutput("rstDepth", 32'(stack_depth), 32'd0);
        checkOutput("rstFault", 32'(fault), 32'd0);
        checkOutput("rstFaultCode", 32'(fault_code), 32'd0);

        applyStimulus(6'b000110, 0, 0, 1'($urandom), 1'($urandom), cyc);
        checkOutput("aluLatency", 32'(cyc), 32'd4);
        checkOutput("aluBackInFetch", 32'(instr_req), 32'd1);

        applyStimulus(6'b100000, 0, 3, 1'b0, 1'b0, cyc);
        checkOutput("loadWaitLatency", 32'(cyc), 32'd7);
        applyStimulus(6'b100010, 0, 0, 1'b0, 1'b0, cyc);
        checkOutput("storeLatency", 32'(cyc), 32'd3);

        applyStimulus(6'b101010, 0, 0, 1'b1, 1'b0, cyc);
        checkOutput("branchTakenLatency", 32'(cyc), 32'd3);
        applyStimulus(6'b101010, 1, 0, 1'b0, 1'b1, cyc);
        applyStimulus(6'b111000, 2, 0, 1'b0, 1'b0, cyc);

        for (int n = 0; n < 150; n++) begin
            do op = 6'($urandom); while (isIllegal(op) && ($urandom_range(0, 9) != 0));
            applyStimulus(op, $urandom_range(0, 2), $urandom_range(0, 3),
                          1'($urandom), 1'($urandom), cyc);
            if (mFault) resetDut();
        end

        resetDut();
        for (int n = 0; n < 8; n++) applyStimulus(6'b111010, 0, 0, 1'b0, 1'b0, cyc);
        checkOutput("callDepth8", 32'(stack_depth), 32'd8);
        applyStimulus(6'b111010, 0, 0, 1'b0, 1'b0, cyc);
        checkOutput("overflowFault", 32'(fault), 32'd1);
        checkOutput("overflowCode", 32'(fault_code), 32'd2);
        checkOutput("overflowNoPush", 32'(push), 32'd0);

        resetDut();
        for (int n = 0; n < 8; n++) applyStimulus(6'b111010, $urandom_range(0, 1), 0, 1'b0, 1'b0, cyc);
        for (int n = 0; n < 8; n++) applyStimulus(6'b111100, $urandom_range(0, 1), 0, 1'b0, 1'b0, cyc);
        checkOutput("retDepth0", 32'(stack_depth), 32'd0);
        applyStimulus(6'b111100, 0, 0, 1'b0, 1'b0, cyc);
        checkOutput("underflowCode", 32'(fault_code), 32'd3);

        resetDut();
        applyStimulus(6'b111101, 0, 0, 1'b0, 1'b0, cyc);
        checkOutput("illegalCode", 32'(fault_code), 32'd1);
        checkOutput("illegalQuietReq", 32'(instr_req), 32'd0);

        resetDut();
        curName     = "midMemReset";
        instr       = {6'b100000, 13'h0};
        instr_ready = 1'b1;
        @(posedge clock);
        #1;
        instr_ready = 1'b0;
        data_ready  = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midMemDataReq", 32'(data_req), 32'd1);
        checkOutput("midMemRead", 32'(mem_read), 32'd1);
        #2;
        init_signal = 1'b1;
        #1;
        checkOutput("asyncResetDataReq", 32'(data_req), 32'd0);
        checkOutput("asyncResetMemRead", 32'(mem_read), 32'd0);
        checkOutput("asyncResetFetch", 32'(instr_req), 32'd1);
        @(posedge clock);
        #1;
        init_signal = 1'b0;
        mDepth = 0;
        mFault = 1'b0;
        mCode  = 2'b00;
        applyStimulus(6'b010100, 0, 0, 1'b0, 1'b0, cyc);

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
